// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - Shared widths and request record for the memory request scheduler
package mem_sched_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int BANK_HI = 15;
  localparam int BANK_LO = 14;
  localparam int REQ_W   = 1 + ADDR_W + DATA_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Synchronous FIFO with occupancy count and full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it is popping in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = storage[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; left unreset because count alone decides which entries are live
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - In-order request issue to composite_memory with credit-limited read returns
module mem_req_scheduler
  import mem_sched_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int REQ_CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  mem_req_t               req_in;
  mem_req_t               req_head;
  logic [REQ_W-1:0]       req_head_bits;
  logic                   req_push;
  logic                   req_full;
  logic                   req_empty;
  logic [REQ_CNT_W-1:0]   req_count;

  logic                   rsp_push;
  logic                   rsp_pop;
  logic                   rsp_full;
  logic                   rsp_empty;
  logic [CNT_W-1:0]       rsp_count;

  logic [CNT_W-1:0]       inflight;
  logic [READ_LAT:0]      rd_mark;
  logic                   credit_ok;
  logic                   issue;
  logic                   issue_rd;

  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_head  = mem_req_t'(req_head_bits);
  assign req_ready = !req_full;
  assign req_push  = req_valid && req_ready;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .wdata (req_in),
    .pop   (issue),
    .rdata (req_head_bits),
    .full  (req_full),
    .empty (req_empty),
    .count (req_count)
  );

  // A read may only leave when its data is guaranteed a response slot; a blocked
  // read holds the head, so everything behind it waits too.
  assign credit_ok = ({1'b0, rsp_count} + {1'b0, inflight}) < (CNT_W + 1)'(RSP_DEPTH);
  assign issue     = !req_empty && (req_head.we || credit_ok);
  assign issue_rd  = issue && !req_head.we;

  // Drive the memory pins from the FIFO head; we is a single-cycle strobe per write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (issue) begin
      mem_we   <= req_head.we;
      mem_addr <= req_head.addr;
      mem_din  <= req_head.wdata;
    end else begin
      mem_we   <= 1'b0;
    end
  end

  // Mark issued reads until their data is on mem_dout, and count them as in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_mark  <= '0;
      inflight <= '0;
    end else begin
      rd_mark <= {rd_mark[READ_LAT-1:0], issue_rd};
      case ({issue_rd, rsp_push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      assert (!(rsp_push && rsp_full));
    end
  end

  // Data is captured on the edge the read mark leaves the tracker
  assign rsp_push  = rd_mark[READ_LAT];
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .wdata (mem_dout),
    .pop   (rsp_pop),
    .rdata (rsp_data),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign busy = (req_count != '0) || (inflight != '0);

endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb/tb_mem_req_scheduler.sv - Scoreboard bench for mem_req_scheduler against a composite_memory model
module tb_mem_req_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_rsp_cyc = -1;
  int last_acc_cyc = 0;
  int we_high = 0;
  int rsp_seen = 0;

  logic [7:0] exp_q [$];
  logic [7:0] shadow [logic [15:0]];
  logic [15:0] addrs [6] = '{16'h0000, 16'h4001, 16'h8002, 16'hC003, 16'h1234, 16'h2222};

  always #5 clk = ~clk;

  mem_req_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy)
  );

  // composite_memory model: write commits on the edge, read data registered one cycle
  logic [7:0] mem_model [0:65535];
  logic [7:0] dout_q;
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_din;
    dout_q <= mem_model[mem_addr];
  end
  assign mem_dout = dout_q;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: pops the scoreboard on every accepted response
  initial forever begin
    logic [7:0] exp;
    @(negedge clk);
    if (mem_we === 1'b1) we_high++;
    if (rst === 1'b0 && rsp_valid === 1'b1) begin
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (rsp_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_extra: got %02h, no response expected", rsp_data);
        end else begin
          exp = exp_q.pop_front();
          rsp_seen++;
          if (rsp_data !== exp) begin
            miscompares++;
            $display("FAIL rsp_data: got %02h want %02h", rsp_data, exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic we, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: req_ready %b want 1 within 200 cycles", req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (we) shadow[a] = d;
      else exp_q.push_back(shadow[a]);
      #1;
      last_acc_cyc = cyc;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++;
    if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_addr: got %04h want 0000", mem_addr); end
    vectors++;
    if (mem_din !== 8'h00) begin miscompares++; $display("FAIL reset_mem_din: got %02h want 00", mem_din); end
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_bank_rw();
    int acc;
    rsp_ready = 1'b1;
    we_high = 0;
    send(1'b1, 16'h0000, 8'hA5);
    send(1'b1, 16'h4001, 8'h5A);
    send(1'b1, 16'h8002, 8'h3C);
    send(1'b1, 16'hC003, 8'h7E);
    first_rsp_cyc = -1;
    send(1'b0, 16'h0000, 8'h00);
    acc = last_acc_cyc;
    send(1'b0, 16'h4001, 8'h00);
    send(1'b0, 16'h8002, 8'h00);
    send(1'b0, 16'hC003, 8'h00);
    drain();
    vectors++;
    if (first_rsp_cyc - acc != 3) begin
      miscompares++;
      $display("FAIL read_latency: got %0d cycles want 3", first_rsp_cyc - acc);
    end
    vectors++;
    if (we_high != 4) begin miscompares++; $display("FAIL we_pulses: got %0d want 4", we_high); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL bank_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int seen0 = rsp_seen;
    rsp_ready = 1'b1;
    send(1'b1, 16'h1234, 8'h11);
    send(1'b0, 16'h1234, 8'h00);
    drain();
    vectors++;
    if (rsp_seen - seen0 != 1) begin miscompares++; $display("FAIL b2b_count: got %0d want 1", rsp_seen - seen0); end
  endtask

  task automatic test_credit_stall();
    int seen0;
    rsp_ready = 1'b1;
    send(1'b1, 16'h2222, 8'h99);
    rsp_ready = 1'b0;
    seen0 = rsp_seen;
    for (int i = 0; i < 6; i++) send(1'b0, addrs[i], 8'h00);
    repeat (6) @(negedge clk);
    vectors++;
    if (mem_addr !== 16'hC003) begin miscompares++; $display("FAIL credit_stall_addr: got %04h want c003", mem_addr); end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL credit_req_ready: got %b want 1", req_ready); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL credit_busy: got %b want 1", busy); end
    vectors++;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL credit_rsp_valid: got %b want 1", rsp_valid); end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();
    vectors++;
    if (rsp_seen - seen0 != 6) begin miscompares++; $display("FAIL credit_count: got %0d want 6", rsp_seen - seen0); end
  endtask

  task automatic test_req_full();
    int seen0 = rsp_seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, addrs[i % 6], 8'h00);
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_req_ready: got %b want 0", req_ready); end
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 16'h4001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_hold_%0d: req_ready %b want 0", i, req_ready); end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    vectors++;
    if (rsp_seen - seen0 != 8) begin miscompares++; $display("FAIL full_count: got %0d want 8", rsp_seen - seen0); end
    repeat (5) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL full_no_extra: rsp_valid %b want 0", rsp_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy: got %b want 0", busy); end
  endtask

  task automatic test_random();
    int seen0 = rsp_seen;
    int nreads = 0;
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic we;
          we = 1'($urandom_range(0, 1));
          if (!we) nreads++;
          send(we, addrs[$urandom_range(0, 5)], 8'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    vectors++;
    if (rsp_seen - seen0 != nreads) begin
      miscompares++;
      $display("FAIL random_count: got %0d want %0d", rsp_seen - seen0, nreads);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL random_busy: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int seen0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, addrs[i], 8'h00);
    send(1'b1, 16'h2222, shadow[16'h2222]);
    @(posedge clk);
    #1;
    vectors++;
    if (mem_we !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_we: got %b want 1", mem_we); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    exp_q.delete();
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL midrst_mem_we: got %b want 0", mem_we); end
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale: rsp_valid %b want 0", rsp_valid); end
    @(posedge clk);
    #1;
    seen0 = rsp_seen;
    send(1'b0, 16'h0000, 8'h00);
    drain();
    vectors++;
    if (rsp_seen - seen0 != 1) begin miscompares++; $display("FAIL midrst_fresh_count: got %0d want 1", rsp_seen - seen0); end
  endtask

  initial begin
    test_reset();
    test_bank_rw();
    test_back_to_back();
    test_credit_stall();
    test_req_full();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_req_scheduler.md
Name: mem_req_scheduler

Overview:
- Front-end stage that sits directly upstream of composite_memory (4 banks, addr[15:14] selects the bank, 16-bit address, 8-bit data, single we, 1-cycle registered read).
- Accepts read/write requests over a valid/ready interface and buffers them in order.
- Issues at most one request per cycle onto composite_memory's clk/we/addr/din/dout pins.
- Returns read data in request order over a valid/ready response interface, with credit-based flow control so in-flight reads never overflow the response buffer.

Parameters:
- REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
- READ_LAT, 1, cycles from the memory sampling addr to mem_dout being valid

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request FIFO not full
- req_we  in  1  1=write, 0=read
- req_addr  in  16  target address
- req_wdata  in  8  write data (ignored on reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts rsp_data
- rsp_data  out  8  read data, in issue order
- mem_we  out  1  to composite_memory we
- mem_addr  out  16  to composite_memory addr
- mem_din  out  8  to composite_memory din
- mem_dout  in  8  from composite_memory dout
- busy  out  1  request FIFO non-empty or reads in flight

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs empty; in-flight tracker cleared.
  - mem_we=0, mem_addr=0, mem_din=0, rsp_valid=0, busy=0.
  - req_ready=1 once rst deasserts.
- Accept:
  - Request is pushed on an edge where req_valid && req_ready.
  - req_ready = !req_full, from registered state only.
  - A full FIFO never accepts, even if it pops in the same cycle.
- Issue:
  - Issue occurs when the request FIFO is non-empty, and only for reads when (rsp_count + inflight) < RSP_DEPTH.
  - On issue, mem_we/mem_addr/mem_din are registered from the FIFO head and the head is popped.
  - mem_we is high for exactly one cycle per write.
  - When not issuing: mem_we=0 and mem_addr/mem_din hold their last values.
  - A read blocked by the credit check stalls all later requests (strict in-order).
- Read tracking:
  - Shift register of depth READ_LAT+1 marks issued reads.
  - mem_dout is captured into the response FIFO on the edge the mark exits (issue edge + 1 + READ_LAT).
- Latency (READ_LAT=1, empty pipeline):
  - Read accepted at edge E: mem_addr valid after E+1, memory samples at E+2, data captured at E+3, rsp_valid high after E+3.
  - Write accepted at E: mem_we high E+1..E+2, committed at E+2.
  - A read issued the cycle after a write to the same address returns the new data.
- Throughput: one request per cycle sustained when rsp_ready=1.
- Response:
  - rsp_valid = !rsp_empty.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both allowed.
  - The credit rule guarantees a push never meets a full FIFO; an assertion checks this.
- busy = !req_empty || inflight != 0.
- Reset mid-operation: queued requests and in-flight reads are discarded; no response is produced for them; mem_we drops immediately (async).
- inflight counter width: clog2(RSP_DEPTH+1).
- rsp_count counts occupied response FIFO entries.

Decomposition:
- Package mem_sched_pkg:
  - ADDR_W=16, DATA_W=8, BANK_HI=15, BANK_LO=14.
  - typedef mem_req_t {we, addr[15:0], wdata[7:0]}.
- One sub-module, sync_fifo (parameterised WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice:
  - request FIFO, WIDTH=25
  - response FIFO, WIDTH=8
- Issue logic, credit check and read shift register live in the top module.

Test Plan:
- Writes 0000=A5, 4001=5A, 8002=3C, C003=7E (one per bank), then reads of the same addresses, rsp_ready=1 -> responses A5,5A,3C,7E in order; first rsp_valid 3 cycles after read accept; mem_we pulses exactly 4 times.
- Back-to-back write 1234=11 then read 1234 on consecutive cycles -> rsp_data=11.
- rsp_ready=0, 6 reads queued -> only 4 issued (mem_addr stops changing), req_ready still 1. Raise rsp_ready -> 6 responses delivered in order, with no loss or duplicate.
- rsp_ready=0, mem stalled, 8 read requests -> req_ready drops after FIFO fills (4 queued beyond the 4 credited); no push while full.
- Simultaneous rsp push and pop with full credits over 20 random read/write cycles -> scoreboard match; overflow assertion never fires.
- Assert rst with 2 reads in flight and 3 queued -> mem_we=0, rsp_valid=0, busy=0 immediately. After release no stale responses; a fresh read of 0000 returns the memory contents.
